// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_ctrl_pkg                                                   |
// | Purpose  : Shared definitions for the core run controller: FSM state       |
// |            encoding, end-cause codes and CSTAT bit positions.              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_HALT = 2'd1;
  localparam logic [1:0] CAUSE_ERR  = 2'd2;
  localparam logic [1:0] CAUSE_WDOG = 2'd3;

  localparam int CSTAT_HALT_BIT = 0;
  localparam int CSTAT_ERR_BIT  = 1;

endpackage
`default_nettype wire

// File: rtl/core_ctrl_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_ctrl_timer                                                 |
// | Purpose  : Loadable down-counter that stops at zero and flags count==1.    |
// | Ports    : clk, rst (async, active-high)                                   |
// |            i_load / i_load_val : load a new count (has priority)           |
// |            i_dec               : decrement by one (holds at zero)          |
// |            o_is_one            : current count equals one                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module core_ctrl_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_is_one
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_is_one = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/core_exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : core_exec_sequencer                                             |
// | Purpose  : Core-clock run controller. A START rising edge holds the core   |
// |            in reset for RST_CYCLES, then enables execution until CSTAT     |
// |            reports halt/error, the watchdog expires or ABORT is raised,    |
// |            and reports the outcome with sticky DONE/ERROR flags.           |
// | Ports    : CCLK, RST (async, active-high)                                  |
// |            START, ABORT, MEM_ADDR, MAX_CYCLES, CSTAT  : control inputs     |
// |            CRST, CEXEC, CMEM_ADDR                     : core pins          |
// |            BUSY, DONE, ERROR, CAUSE, CYCLES, LAST_STAT: status             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module core_exec_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CCLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [31:0]          MEM_ADDR,
  input  logic [CNT_WIDTH-1:0] MAX_CYCLES,
  input  logic [7:0]           CSTAT,
  output logic                 CRST,
  output logic                 CEXEC,
  output logic [31:0]          CMEM_ADDR,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR,
  output logic [1:0]           CAUSE,
  output logic [CNT_WIDTH-1:0] CYCLES,
  output logic [7:0]           LAST_STAT
);

  localparam int TMR_W = $clog2(RST_CYCLES + 1);

  state_t               r_state,  w_state_nxt;
  logic                 r_start_q;
  logic                 r_crst, r_cexec, r_busy;
  logic                 r_done,   w_done_nxt;
  logic                 r_error,  w_error_nxt;
  logic [1:0]           r_cause,  w_cause_nxt;
  logic [CNT_WIDTH-1:0] r_cycles, w_cycles_nxt;
  logic [CNT_WIDTH-1:0] r_max,    w_max_nxt;
  logic [31:0]          r_maddr,  w_maddr_nxt;
  logic [7:0]           r_last,   w_last_nxt;

  logic                 w_start_edge;
  logic                 w_tmr_load;
  logic                 w_tmr_one;
  logic [CNT_WIDTH-1:0] w_cycles_sat;
  logic                 w_wdog_hit;

  assign w_start_edge = START & ~r_start_q;
  assign w_cycles_sat = (&r_cycles) ? r_cycles : (r_cycles + CNT_WIDTH'(1));
  // Compare in CNT_WIDTH arithmetic: a saturated counter wraps to 0 here,
  // which never matches a non-zero limit.
  assign w_wdog_hit   = (r_max != '0) && ((r_cycles + CNT_WIDTH'(1)) == r_max);

  core_ctrl_timer #(
    .WIDTH (TMR_W)
  ) u_rst_timer (
    .clk        (CCLK),
    .rst        (RST),
    .i_load     (w_tmr_load),
    .i_load_val (TMR_W'(RST_CYCLES)),
    .i_dec      (r_state == ST_RESET),
    .o_is_one   (w_tmr_one)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_load   = 1'b0;
    w_maddr_nxt  = r_maddr;
    w_max_nxt    = r_max;
    w_done_nxt   = r_done;
    w_error_nxt  = r_error;
    w_cause_nxt  = r_cause;
    w_cycles_nxt = r_cycles;
    w_last_nxt   = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge && !ABORT) begin
          w_maddr_nxt  = MEM_ADDR;
          w_max_nxt    = MAX_CYCLES;
          w_done_nxt   = 1'b0;
          w_error_nxt  = 1'b0;
          w_cause_nxt  = CAUSE_NONE;
          w_cycles_nxt = '0;
          w_last_nxt   = '0;
          w_tmr_load   = 1'b1;
          w_state_nxt  = ST_RESET;
        end
      end
      ST_RESET: begin
        if (ABORT) begin
          w_cause_nxt = CAUSE_ERR;
          w_error_nxt = 1'b1;
          w_last_nxt  = CSTAT;
          w_state_nxt = ST_FINISH;
        end else if (w_tmr_one) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // The exit cycle is itself an execute cycle, so it is counted.
        w_cycles_nxt = w_cycles_sat;
        if (ABORT || CSTAT[CSTAT_ERR_BIT]) begin
          w_cause_nxt = CAUSE_ERR;
          w_error_nxt = 1'b1;
          w_last_nxt  = CSTAT;
          w_state_nxt = ST_FINISH;
        end else if (CSTAT[CSTAT_HALT_BIT]) begin
          w_cause_nxt = CAUSE_HALT;
          w_done_nxt  = 1'b1;
          w_last_nxt  = CSTAT;
          w_state_nxt = ST_FINISH;
        end else if (w_wdog_hit) begin
          w_cause_nxt = CAUSE_WDOG;
          w_error_nxt = 1'b1;
          w_last_nxt  = CSTAT;
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (!START) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pin outputs are decoded from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b1;
      r_crst    <= 1'b1;
      r_cexec   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_cycles  <= '0;
      r_max     <= '0;
      r_maddr   <= '0;
      r_last    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= START;
      r_crst    <= (w_state_nxt == ST_RESET);
      r_cexec   <= (w_state_nxt == ST_RUN);
      r_busy    <= (w_state_nxt == ST_RESET) || (w_state_nxt == ST_RUN);
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
      r_cause   <= w_cause_nxt;
      r_cycles  <= w_cycles_nxt;
      r_max     <= w_max_nxt;
      r_maddr   <= w_maddr_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign CRST      = r_crst;
  assign CEXEC     = r_cexec;
  assign CMEM_ADDR = r_maddr;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERROR     = r_error;
  assign CAUSE     = r_cause;
  assign CYCLES    = r_cycles;
  assign LAST_STAT = r_last;

endmodule
`default_nettype wire

// File: tb/tb_core_exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_core_exec_sequencer                                          |
// | Purpose  : Self-checking bench for core_exec_sequencer: directed scenarios |
// |            followed by randomized traffic, all compared every cycle       |
// |            against a run-level behavioural model.                         |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_core_exec_sequencer;

  localparam int RST_CYCLES = 4;
  localparam int CNT_WIDTH  = 32;

  logic                 CCLK = 1'b0;
  logic                 RST  = 1'b1;
  logic                 START = 1'b1;
  logic                 ABORT = 1'b0;
  logic [31:0]          MEM_ADDR = '0;
  logic [CNT_WIDTH-1:0] MAX_CYCLES = '0;
  logic [7:0]           CSTAT = '0;
  logic                 CRST, CEXEC, BUSY, DONE, ERROR;
  logic [31:0]          CMEM_ADDR;
  logic [1:0]           CAUSE;
  logic [CNT_WIDTH-1:0] CYCLES;
  logic [7:0]           LAST_STAT;

  core_exec_sequencer #(
    .RST_CYCLES (RST_CYCLES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .CCLK       (CCLK),
    .RST        (RST),
    .START      (START),
    .ABORT      (ABORT),
    .MEM_ADDR   (MEM_ADDR),
    .MAX_CYCLES (MAX_CYCLES),
    .CSTAT      (CSTAT),
    .CRST       (CRST),
    .CEXEC      (CEXEC),
    .CMEM_ADDR  (CMEM_ADDR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .CAUSE      (CAUSE),
    .CYCLES     (CYCLES),
    .LAST_STAT  (LAST_STAT)
  );

  always #5 CCLK = ~CCLK;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is described by how many core-reset cycles remain, whether the core
  // is executing, and whether a finished run is waiting for START to drop.
  bit             m_por        = 1'b1;
  bit             m_prev_start = 1'b1;
  int             m_rst_left   = 0;
  bit             m_exec       = 1'b0;
  bit             m_hold       = 1'b0;
  bit             m_done       = 1'b0;
  bit             m_err        = 1'b0;
  logic [1:0]     m_cause      = 2'd0;
  logic [31:0]    m_addr       = '0;
  logic [31:0]    m_max        = '0;
  logic [31:0]    m_cycles     = '0;
  logic [7:0]     m_last       = '0;
  bit             m_edge;
  logic [32:0]    m_next_cnt;
  bit             m_wd;

  task automatic m_end(input logic [1:0] cause, input bit is_err);
    m_cause = cause;
    if (is_err) m_err = 1'b1;
    else        m_done = 1'b1;
    m_last  = CSTAT;
    m_exec  = 1'b0;
    m_rst_left = 0;
    m_hold  = 1'b1;
  endtask

  always @(posedge CCLK or posedge RST) begin
    if (RST) begin
      m_por = 1'b1; m_prev_start = 1'b1; m_rst_left = 0; m_exec = 1'b0; m_hold = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_cause = 2'd0; m_addr = '0; m_max = '0;
      m_cycles = '0; m_last = '0;
    end else begin
      m_edge = START && !m_prev_start;
      m_prev_start = START;
      m_por = 1'b0;
      if (m_rst_left > 0) begin
        if (ABORT) m_end(2'd2, 1'b1);
        else begin
          m_rst_left--;
          if (m_rst_left == 0) m_exec = 1'b1;
        end
      end else if (m_exec) begin
        m_next_cnt = {1'b0, m_cycles} + 33'd1;
        m_wd = (m_max != 0) && (m_next_cnt == {1'b0, m_max});
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        if (ABORT || CSTAT[1]) m_end(2'd2, 1'b1);
        else if (CSTAT[0])     m_end(2'd1, 1'b0);
        else if (m_wd)         m_end(2'd3, 1'b1);
      end else if (m_hold) begin
        if (!START) m_hold = 1'b0;
      end else if (m_edge && !ABORT) begin
        m_addr = MEM_ADDR; m_max = MAX_CYCLES;
        m_done = 1'b0; m_err = 1'b0; m_cause = 2'd0; m_cycles = '0; m_last = '0;
        m_rst_left = RST_CYCLES;
      end
    end
  end

  always @(negedge CCLK) begin
    if (cmp_en) begin
      chk("crst",      CRST,      m_por || (m_rst_left > 0));
      chk("cexec",     CEXEC,     m_exec);
      chk("busy",      BUSY,      (m_rst_left > 0) || m_exec);
      chk("cmem_addr", CMEM_ADDR, m_addr);
      chk("done",      DONE,      m_done);
      chk("error",     ERROR,     m_err);
      chk("cause",     CAUSE,     m_cause);
      chk("cycles",    CYCLES,    m_cycles);
      chk("last_stat", LAST_STAT, m_last);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge CCLK);
    #1;
  endtask

  // Leaves the bench in the first RESET cycle; mid-run input changes follow.
  task automatic launch(input logic [31:0] addr, input logic [31:0] maxc);
    MEM_ADDR = addr; MAX_CYCLES = maxc; START = 1'b0;
    tick();
    START = 1'b1;
    tick();
    MEM_ADDR = $urandom; MAX_CYCLES = 32'd3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int guard;
    int r;
    RST = 1'b1; START = 1'b1;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_crst",   CRST, 1);
    chk("rst_cexec",  CEXEC, 0);
    chk("rst_cycles", CYCLES, 0);

    // 1: START already high at release must not launch
    RST = 1'b0;
    repeat (20) tick();
    chk("t1_crst",  CRST, 0);
    chk("t1_cexec", CEXEC, 0);
    chk("t1_busy",  BUSY, 0);

    // 2: normal halt
    launch(32'h0000_0100, 32'd0);
    for (int i = 0; i < RST_CYCLES; i++) begin
      if (i > 0) tick();
      chk("t2_crst_hold", CRST, 1);
      chk("t2_cexec_lo",  CEXEC, 0);
    end
    tick();
    chk("t2_cexec_on", CEXEC, 1);
    chk("t2_crst_off", CRST, 0);
    chk("t2_addr",     CMEM_ADDR, 32'h100);
    repeat (9) tick();
    CSTAT = 8'h01;
    tick();
    CSTAT = 8'h00;
    chk("t2_cexec_off", CEXEC, 0);
    chk("t2_done",      DONE, 1);
    chk("t2_cause",     CAUSE, 1);
    chk("t2_cycles",    CYCLES, 10);
    chk("t2_last",      LAST_STAT, 8'h01);
    chk("t2_model_cycles", m_cycles, 10);
    START = 1'b0;
    tick();

    // 3: watchdog at 8
    launch(32'h0000_0200, 32'd8);
    cnt = 0; guard = 0;
    while (!ERROR && guard < 60) begin
      if (CEXEC) cnt++;
      tick();
      guard++;
    end
    chk("t3_no_timeout", guard < 60, 1);
    chk("t3_exec_cnt",   cnt, 8);
    chk("t3_cause",      CAUSE, 3);
    chk("t3_cycles",     CYCLES, 8);
    chk("t3_done",       DONE, 0);
    START = 1'b0;
    tick();

    // 4: error beats simultaneous halt
    launch(32'h0000_0300, 32'd0);
    repeat (RST_CYCLES) tick();
    CSTAT = 8'h03;
    tick();
    CSTAT = 8'h00;
    chk("t4_cause", CAUSE, 2);
    chk("t4_error", ERROR, 1);
    chk("t4_done",  DONE, 0);
    chk("t4_last",  LAST_STAT, 8'h03);
    START = 1'b0;
    tick();

    // 5: abort during RESET
    launch(32'h0000_0400, 32'd0);
    tick();
    chk("t5_crst", CRST, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t5_busy",   BUSY, 0);
    chk("t5_cexec",  CEXEC, 0);
    chk("t5_cause",  CAUSE, 2);
    chk("t5_error",  ERROR, 1);
    chk("t5_cycles", CYCLES, 0);
    START = 1'b0;
    tick();

    // 6: async reset mid-run, then FINISH ignores a START edge
    launch(32'h0000_0500, 32'd0);
    repeat (RST_CYCLES + 1) tick();
    chk("t6_running", CEXEC, 1);
    RST = 1'b1;
    #1;
    chk("t6_async_crst",  CRST, 1);
    chk("t6_async_cexec", CEXEC, 0);
    tick(); tick();
    RST = 1'b0;
    repeat (5) tick();
    chk("t6_no_relaunch", BUSY, 0);
    START = 1'b0;
    tick();
    START = 1'b1;
    tick();
    chk("t6_relaunch", CRST, 1);
    repeat (RST_CYCLES + 2) tick();
    CSTAT = 8'h01; START = 1'b0;
    tick();
    CSTAT = 8'h00; START = 1'b1;
    tick();
    chk("t6_fin_busy", BUSY, 0);
    chk("t6_fin_crst", CRST, 0);
    chk("t6_fin_done", DONE, 1);
    repeat (3) tick();
    chk("t6_edge_ignored", CRST, 0);
    START = 1'b0;
    tick();
    START = 1'b1;
    tick();
    chk("t6_new_run", CRST, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0; START = 1'b0;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) START = ~START;
      ABORT = ($urandom_range(0, 59) == 0);
      r = $urandom_range(0, 99);
      CSTAT = {6'($urandom), 2'b00};
      if (r < 3)      CSTAT[0] = 1'b1;
      else if (r < 5) CSTAT[1:0] = 2'($urandom_range(2, 3));
      MEM_ADDR   = $urandom;
      MAX_CYCLES = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
      RST = ($urandom_range(0, 799) == 0);
      tick();
    end
    RST = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
